// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The Ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             Ovf;

  modport master (output start, A, B, Bin, input busy, done, D, Bout, Ovf);
  modport slave  (input start, A, B, Bin, output busy, done, D, Bout, Ovf);
`else
  modport master (output start, A, B, Bin, input busy, done, D, Bout);
  modport slave  (input start, A, B, Bin, output busy, done, D, Bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B - Bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
`endif

  logic             bit_a, bit_b, diff_bit, br_next;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell shared by every bit position.
  assign bit_a     = a_sh_q[0];
  assign bit_b     = b_sh_q[0];
  assign diff_bit  = bit_a ^ bit_b ^ br_q;
  assign br_next   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
  assign res_shift = {diff_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_sh_d  = bus.A;
          b_sh_d  = bus.B;
          br_d    = bus.Bin;
          res_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
`endif
        end
      end
      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // Publish on the final bit so D/Bout are valid in the DONE cycle.
          state_d = StDone;
          d_d     = res_shift;
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
`endif
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed plan cases plus random operands
// against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide subtraction; the extra top bit is the unsigned borrow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bout, output logic ovf);
    logic [W:0] full;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d    = full[W-1:0];
    bout = full[W];
    ovf  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input string tag);
    logic [W-1:0] ed, prev_d;
    logic         eb, eo, prev_b;
    int           n;
    model(a, b, bin, ed, eb, eo);
    prev_d    = bus.D;
    prev_b    = bus.Bout;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Bin   = ~bin;
    check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    n = 0;
    for (int i = 1; i <= int'(W) + 4; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (bus.done) break;
      if (i < 3) check({tag, " d_held_in_run"}, {bus.Bout, bus.D}, {prev_b, prev_d});
    end
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " busy_in_done"}, 32'(bus.busy), 32'd1);
    check({tag, " D"}, 32'(bus.D), 32'(ed));
    check({tag, " Bout"}, 32'(bus.Bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " Ovf"}, 32'(bus.Ovf), 32'(eo));
`endif
    @(posedge clk);
    #1;
    check({tag, " idle_after"}, {bus.busy, bus.done}, 32'd0);
    check({tag, " D_hold"}, 32'(bus.D), 32'(ed));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    int           done_cnt;

    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'h5A;
    bus.B     = 8'h3C;
    bus.Bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset D", 32'(bus.D), 32'd0);
    check("reset Bout", 32'(bus.Bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset Ovf", 32'(bus.Ovf), 32'd0);
`endif
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;

    do_op(8'h5A, 8'h3C, 1'b0, "op5a3c");
    do_op(8'h00, 8'h01, 1'b0, "op0001");
    do_op(8'h80, 8'h01, 1'b0, "op8001");
    do_op(8'h10, 8'h0F, 1'b1, "op100f");
    do_op(8'h0F, 8'h0F, 1'b1, "opeqbin");
    do_op(8'hFF, 8'hFF, 1'b0, "opffff");

    for (int i = 0; i < 24; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      do_op(ra, rb, rbin, "rand");
    end

    // start held high; operands change during RUN and must not leak in.
    bus.A     = 8'h5A;
    bus.B     = 8'h3C;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.A    = 8'hFF;
    bus.B    = 8'h00;
    done_cnt = 0;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
      if (c == 8) begin
        check("held first done", 32'(bus.done), 32'd1);
        check("held first D", {bus.Bout, bus.D}, {1'b0, 8'h1E});
      end
      if (c == 9) check("held idle gap", 32'(bus.busy), 32'd0);
      if (c == 10) check("held accept k+10", 32'(bus.busy), 32'd1);
      if (c == 18) begin
        check("held second done", 32'(bus.done), 32'd1);
        check("held second D", {bus.Bout, bus.D}, {1'b0, 8'hFF});
      end
    end
    bus.start = 1'b0;
    check("held done count", 32'(done_cnt), 32'd2);
    @(posedge clk);
    #1;

    // Reset during RUN bit 4 aborts the operation.
    do_op(8'h5A, 8'h3C, 1'b0, "prerst");
    bus.A     = 8'h00;
    bus.B     = 8'h01;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort running", 32'(bus.busy), 32'd1);
    check("abort D held", 32'(bus.D), 32'h1E);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort D", 32'(bus.D), 32'd0);
    check("abort Bout", 32'(bus.Bout), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    check("abort no done", 32'(done_cnt), 32'd0);
    do_op(8'h33, 8'h44, 1'b1, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
